// File: rtl/stream_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkt_buf
// Description : Stream FIFO buffer. Runs as cut-through or store-and-forward,
//               and drops packets larger than the storage depth.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_pkt_buf #(
    parameter int DEPTH       = 16,
    parameter int ID_WIDTH    = 1,
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_WIDTH  = 1,
    parameter int USER_WIDTH  = 1,
    parameter int PACKET_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_t_valid,
    output logic                      s_t_ready,
    input  logic [ID_WIDTH-1:0]       s_t_id,
    input  logic [DEST_WIDTH-1:0]     s_t_dest,
    input  logic [DATA_WIDTH-1:0]     s_t_data,
    input  logic [DATA_WIDTH/8-1:0]   s_t_strb,
    input  logic [DATA_WIDTH/8-1:0]   s_t_keep,
    input  logic                      s_t_last,
    input  logic [USER_WIDTH-1:0]     s_t_user,
    output logic                      m_t_valid,
    input  logic                      m_t_ready,
    output logic [ID_WIDTH-1:0]       m_t_id,
    output logic [DEST_WIDTH-1:0]     m_t_dest,
    output logic [DATA_WIDTH-1:0]     m_t_data,
    output logic [DATA_WIDTH/8-1:0]   m_t_strb,
    output logic [DATA_WIDTH/8-1:0]   m_t_keep,
    output logic                      m_t_last,
    output logic [USER_WIDTH-1:0]     m_t_user,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      drop
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_pw = c_aw + 1;
    localparam int c_sw = DATA_WIDTH / 8;
    localparam int c_ew = ID_WIDTH + DEST_WIDTH + DATA_WIDTH + 2 * c_sw + 1 + USER_WIDTH;
    localparam logic [c_pw-1:0] c_full = c_pw'(DEPTH);
    localparam logic [c_pw-1:0] c_one  = c_pw'(1);

    typedef enum logic [0:0] {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    logic [c_ew-1:0] r_mem [DEPTH];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_pw-1:0] r_commit_ptr;
    state_t          r_state;
    logic            r_ready;
    logic            r_drop;

    logic            w_s_fire;
    logic            w_m_fire;
    logic            w_write;
    logic [c_ew-1:0] w_s_beat;
    logic [c_ew-1:0] w_rd_beat;
    logic [c_pw-1:0] w_avail_ptr;
    logic [c_pw-1:0] w_uncommitted;
    logic [c_pw-1:0] w_wr_next;
    logic [c_pw-1:0] w_rd_next;
    logic [c_pw-1:0] w_commit_next;
    logic [c_pw-1:0] w_level_next;
    logic [c_pw-1:0] w_uncom_next;
    state_t          w_state_next;
    logic            w_drop_next;
    logic            w_ready_next;

    assign w_s_fire      = s_t_valid & r_ready;
    assign w_m_fire      = m_t_valid & m_t_ready;
    assign w_s_beat      = {s_t_id, s_t_dest, s_t_data, s_t_strb, s_t_keep, s_t_last, s_t_user};
    // Store-and-forward exposes only whole packets to the reader
    assign w_avail_ptr   = (PACKET_MODE != 0) ? r_commit_ptr : r_wr_ptr;
    assign w_uncommitted = r_wr_ptr - r_commit_ptr;
    assign w_rd_beat     = r_mem[r_rd_ptr[c_aw-1:0]];

    assign m_t_valid = (r_rd_ptr != w_avail_ptr);
    assign {m_t_id, m_t_dest, m_t_data, m_t_strb, m_t_keep, m_t_last, m_t_user} = w_rd_beat;
    assign level     = r_wr_ptr - r_rd_ptr;
    assign s_t_ready = r_ready;
    assign drop      = r_drop;

    always_comb begin
        w_wr_next     = r_wr_ptr;
        w_commit_next = r_commit_ptr;
        w_state_next  = r_state;
        w_drop_next   = 1'b0;
        w_write       = 1'b0;
        w_rd_next     = w_m_fire ? (r_rd_ptr + c_one) : r_rd_ptr;
        if (PACKET_MODE == 0) begin
            if (w_s_fire) begin
                w_write   = 1'b1;
                w_wr_next = r_wr_ptr + c_one;
            end
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (w_s_fire) begin
                        if (w_uncommitted == c_full) begin
                            // Packet cannot fit: forget its stored beats
                            w_wr_next   = r_commit_ptr;
                            w_drop_next = 1'b1;
                            if (!s_t_last) begin
                                w_state_next = ST_DISCARD;
                            end
                        end else begin
                            w_write   = 1'b1;
                            w_wr_next = r_wr_ptr + c_one;
                            if (s_t_last) begin
                                w_commit_next = r_wr_ptr + c_one;
                            end
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_s_fire && s_t_last) begin
                        w_state_next = ST_ACCEPT;
                    end
                end
                default: w_state_next = ST_ACCEPT;
            endcase
        end
    end

    assign w_level_next = w_wr_next - w_rd_next;
    assign w_uncom_next = w_wr_next - w_commit_next;
    // A full packet in flight must still be accepted so it can be discarded
    assign w_ready_next = (w_level_next != c_full) ||
                          ((PACKET_MODE != 0) &&
                           ((w_uncom_next == c_full) || (w_state_next == ST_DISCARD)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_state      <= ST_ACCEPT;
            r_ready      <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_next;
            r_rd_ptr     <= w_rd_next;
            r_commit_ptr <= w_commit_next;
            r_state      <= w_state_next;
            r_ready      <= w_ready_next;
            r_drop       <= w_drop_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= w_s_beat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_pkt_buf
// Description : Bench for stream_pkt_buf: one cut-through and two
//               store-and-forward instances checked against a packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_pkt_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       s_valid, s_ready, s_last, m_valid, m_ready, m_last, drop;
    logic [2:0][1:0]  s_id, s_dest, s_strb, s_keep, m_id, m_dest, m_strb, m_keep;
    logic [2:0][15:0] s_data, m_data;
    logic [2:0][2:0]  s_user, m_user;
    logic [2:0][3:0]  level;

    int n_cmp = 0;
    int n_err = 0;

    // Instance 0: cut-through depth 4; 1: packet depth 8; 2: packet depth 4
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D  = (g == 1) ? 8 : 4;
        localparam int PM = (g == 0) ? 0 : 1;
        logic [$clog2(D):0] lv;
        stream_pkt_buf #(
            .DEPTH(D), .ID_WIDTH(2), .DATA_WIDTH(16), .DEST_WIDTH(2),
            .USER_WIDTH(3), .PACKET_MODE(PM)
        ) u_dut (
            .clk(clk), .rst(rst),
            .s_t_valid(s_valid[g]), .s_t_ready(s_ready[g]), .s_t_id(s_id[g]),
            .s_t_dest(s_dest[g]), .s_t_data(s_data[g]), .s_t_strb(s_strb[g]),
            .s_t_keep(s_keep[g]), .s_t_last(s_last[g]), .s_t_user(s_user[g]),
            .m_t_valid(m_valid[g]), .m_t_ready(m_ready[g]), .m_t_id(m_id[g]),
            .m_t_dest(m_dest[g]), .m_t_data(m_data[g]), .m_t_strb(m_strb[g]),
            .m_t_keep(m_keep[g]), .m_t_last(m_last[g]), .m_t_user(m_user[g]),
            .level(lv), .drop(drop[g])
        );
        assign level[g] = 4'(lv);
    end

    function automatic logic [27:0] pk_s(input int k);
        return {s_id[k], s_dest[k], s_data[k], s_strb[k], s_keep[k], s_last[k], s_user[k]};
    endfunction

    function automatic logic [27:0] pk_m(input int k);
        return {m_id[k], m_dest[k], m_data[k], m_strb[k], m_keep[k], m_last[k], m_user[k]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_side(input int k);
        s_id[k]   = 2'($urandom);
        s_dest[k] = 2'($urandom);
        s_data[k] = 16'($urandom);
        s_strb[k] = 2'($urandom);
        s_keep[k] = 2'($urandom);
        s_user[k] = 3'($urandom);
    endtask

    task automatic test_reset();
        s_valid = '0; m_ready = '0; s_last = '0;
        for (int k = 0; k < 3; k++) rand_side(k);
        rst = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (s_ready[k] !== 1'b0 || m_valid[k] !== 1'b0 || level[k] !== 4'd0 || drop[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state[%0d]: got rdy=%b val=%b lvl=%0d drop=%b expected 0 0 0 0",
                         k, s_ready[k], m_valid[k], level[k], drop[k]);
            end
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (s_ready[k] !== 1'b1) begin
                n_err++;
                $display("FAIL ready_after_reset[%0d]: got %b expected 1", k, s_ready[k]);
            end
        end
    endtask

    task automatic test_cut_through();
        m_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 16'(8'h11 * (i + 1));
            s_last[0]  = (i == 3);
            n_cmp++;
            if (s_ready[0] !== 1'b1) begin
                n_err++;
                $display("FAIL ct_ready_beat%0d: got %b expected 1", i, s_ready[0]);
            end
            tick();
            if (i == 0) begin
                n_cmp++;
                if (m_valid[0] !== 1'b1 || m_data[0] !== 16'h0011) begin
                    n_err++;
                    $display("FAIL ct_latency: got valid=%b data=%h expected 1 0011", m_valid[0], m_data[0]);
                end
            end
        end
        s_valid[0] = 1'b0;
        n_cmp++;
        if (level[0] !== 4'd4 || s_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ct_full: got level=%0d ready=%b expected 4 0", level[0], s_ready[0]);
        end
        m_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (m_valid[0] !== 1'b1 || m_data[0] !== 16'(8'h11 * (i + 1)) || m_last[0] !== (i == 3)) begin
                n_err++;
                $display("FAIL ct_out%0d: got valid=%b data=%h last=%b expected 1 %h %b",
                         i, m_valid[0], m_data[0], m_last[0], 16'(8'h11 * (i + 1)), (i == 3));
            end
            tick();
        end
        m_ready[0] = 1'b0;
        n_cmp++;
        if (level[0] !== 4'd0 || m_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ct_drained: got level=%0d valid=%b expected 0 0", level[0], m_valid[0]);
        end
    endtask

    task automatic test_store_forward();
        m_ready[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid[1] = 1'b1;
            s_data[1]  = 16'hA000 + 16'(i);
            s_last[1]  = (i == 2);
            n_cmp++;
            if (m_valid[1] !== 1'b0 || s_ready[1] !== 1'b1) begin
                n_err++;
                $display("FAIL sf_hold%0d: got valid=%b ready=%b expected 0 1", i, m_valid[1], s_ready[1]);
            end
            tick();
        end
        s_valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (m_valid[1] !== 1'b1 || m_data[1] !== 16'hA000 + 16'(i) || m_last[1] !== (i == 2)) begin
                n_err++;
                $display("FAIL sf_out%0d: got valid=%b data=%h last=%b expected 1 %h %b",
                         i, m_valid[1], m_data[1], m_last[1], 16'hA000 + 16'(i), (i == 2));
            end
            tick();
        end
        m_ready[1] = 1'b0;
        n_cmp++;
        if (level[1] !== 4'd0 || m_valid[1] !== 1'b0) begin
            n_err++;
            $display("FAIL sf_drained: got level=%0d valid=%b expected 0 0", level[1], m_valid[1]);
        end
    endtask

    task automatic test_drop();
        int sent = 0, cyc = 0, drops = 0, outs = 0, got = 0;
        logic [15:0] seen [2];
        m_ready[2] = 1'b1;
        while (sent < 6 && cyc < 50) begin
            s_valid[2] = 1'b1;
            s_data[2]  = 16'h0100 + 16'(sent);
            s_last[2]  = (sent == 5);
            if (m_valid[2]) outs++;
            if (s_ready[2]) sent++;
            tick();
            cyc++;
            drops += int'(drop[2]);
        end
        s_valid[2] = 1'b0;
        n_cmp++;
        if (level[2] !== 4'd0 || sent != 6) begin
            n_err++;
            $display("FAIL drop_level: got level=%0d sent=%0d expected 0 6", level[2], sent);
        end
        repeat (2) begin
            if (m_valid[2]) outs++;
            tick();
            drops += int'(drop[2]);
        end
        n_cmp++;
        if (drops != 1 || outs != 0) begin
            n_err++;
            $display("FAIL drop_pulse: got drops=%0d outs=%0d expected 1 0", drops, outs);
        end
        for (int i = 0; i < 2; i++) begin
            s_valid[2] = 1'b1;
            s_data[2]  = 16'h0B01 + 16'(i);
            s_last[2]  = (i == 1);
            n_cmp++;
            if (s_ready[2] !== 1'b1) begin
                n_err++;
                $display("FAIL drop_next_ready%0d: got %b expected 1", i, s_ready[2]);
            end
            tick();
        end
        s_valid[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (m_valid[2]) begin
                if (got < 2) seen[got] = m_data[2];
                got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 2 || seen[0] !== 16'h0B01 || seen[1] !== 16'h0B02) begin
            n_err++;
            $display("FAIL drop_next_pkt: got count=%0d %h %h expected 2 0b01 0b02", got, seen[0], seen[1]);
        end
        m_ready[2] = 1'b0;
    endtask

    task automatic test_random_stream();
        logic [27:0] q[$];
        logic [27:0] exp_b, held;
        logic was_stall = 1'b0;
        int sent = 0, rcvd = 0, cyc = 0;
        while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            s_valid[0] = (sent < 1000) && ($urandom_range(0, 3) != 0);
            rand_side(0);
            s_last[0]  = 1'($urandom);
            m_ready[0] = ($urandom_range(0, 3) != 0);
            n_cmp++;
            if (level[0] !== 4'(q.size()) || level[0] > 4'd4) begin
                n_err++;
                $display("FAIL rnd_level: got %0d expected %0d", level[0], q.size());
            end
            n_cmp++;
            if (drop[0] !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_drop_inert: got %b expected 0", drop[0]);
            end
            if (was_stall) begin
                n_cmp++;
                if (m_valid[0] !== 1'b1 || pk_m(0) !== held) begin
                    n_err++;
                    $display("FAIL rnd_stable: got valid=%b beat=%h expected 1 %h", m_valid[0], pk_m(0), held);
                end
            end
            if (m_valid[0] && m_ready[0]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd_extra_beat: got %h expected none", pk_m(0));
                end else begin
                    exp_b = q.pop_front();
                    if (pk_m(0) !== exp_b) begin
                        n_err++;
                        $display("FAIL rnd_beat%0d: got %h expected %h", rcvd, pk_m(0), exp_b);
                    end
                end
                rcvd++;
            end
            if (s_valid[0] && s_ready[0]) begin
                q.push_back(pk_s(0));
                sent++;
            end
            was_stall = m_valid[0] && !m_ready[0];
            held = pk_m(0);
            tick();
            cyc++;
        end
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b0;
        n_cmp++;
        if (rcvd != 1000) begin
            n_err++;
            $display("FAIL rnd_count: got %0d expected 1000", rcvd);
        end
    endtask

    task automatic test_random_packets();
        logic [27:0] cur[$];
        logic [27:0] q[$];
        logic [27:0] exp_b;
        int pkts = 0, len = 1, idx = 0, cyc = 0, exp_drops = 0, drops = 0, rcvd = 0, exp_rcvd = 0;
        len = $urandom_range(1, 6);
        while ((pkts < 60 || q.size() > 0) && cyc < 20000) begin
            s_valid[2] = (pkts < 60) && ($urandom_range(0, 2) != 0);
            rand_side(2);
            s_last[2]  = (idx == len - 1);
            m_ready[2] = ($urandom_range(0, 2) != 0);
            drops += int'(drop[2]);
            if (m_valid[2] && m_ready[2]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL pkt_extra_beat: got %h expected none", pk_m(2));
                end else begin
                    exp_b = q.pop_front();
                    if (pk_m(2) !== exp_b) begin
                        n_err++;
                        $display("FAIL pkt_beat%0d: got %h expected %h", rcvd, pk_m(2), exp_b);
                    end
                end
                rcvd++;
            end
            if (s_valid[2] && s_ready[2]) begin
                cur.push_back(pk_s(2));
                idx++;
                if (s_last[2]) begin
                    // A packet survives only if it fits entirely in storage
                    if (cur.size() <= 4) begin
                        foreach (cur[i]) q.push_back(cur[i]);
                        exp_rcvd += cur.size();
                    end else begin
                        exp_drops++;
                    end
                    cur.delete();
                    pkts++;
                    idx = 0;
                    len = $urandom_range(1, 6);
                end
            end
            tick();
            cyc++;
        end
        s_valid[2] = 1'b0;
        m_ready[2] = 1'b0;
        repeat (2) begin
            tick();
            drops += int'(drop[2]);
        end
        n_cmp++;
        if (drops != exp_drops || rcvd != exp_rcvd) begin
            n_err++;
            $display("FAIL pkt_totals: got drops=%0d beats=%0d expected %0d %0d", drops, rcvd, exp_drops, exp_rcvd);
        end
    endtask

    task automatic test_reset_mid_packet();
        int got = 0;
        logic [15:0] seen [2];
        m_ready[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_valid[1] = 1'b1;
            s_data[1]  = 16'hDE00 + 16'(i);
            s_last[1]  = 1'b0;
            tick();
        end
        s_valid[1] = 1'b0;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (m_valid[1] !== 1'b0 || level[1] !== 4'd0) begin
            n_err++;
            $display("FAIL rstmid_state: got valid=%b level=%0d expected 0 0", m_valid[1], level[1]);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            s_valid[1] = 1'b1;
            s_data[1]  = 16'h00C1 + 16'(i);
            s_last[1]  = (i == 1);
            n_cmp++;
            if (s_ready[1] !== 1'b1) begin
                n_err++;
                $display("FAIL rstmid_ready%0d: got %b expected 1", i, s_ready[1]);
            end
            tick();
        end
        s_valid[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (m_valid[1]) begin
                if (got < 2) seen[got] = m_data[1];
                got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 2 || seen[0] !== 16'h00C1 || seen[1] !== 16'h00C2) begin
            n_err++;
            $display("FAIL rstmid_output: got count=%0d %h %h expected 2 00c1 00c2", got, seen[0], seen[1]);
        end
        m_ready[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cut_through();
        test_store_forward();
        test_drop();
        test_random_stream();
        test_random_packets();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_pkt_buf.md
STREAM_PKT_BUF -- requirements
Module: stream_pkt_buf

Interface
REQ-001 Parameter DEPTH, default 16: storage depth in beats; SHALL be a power of two and at least 2.
REQ-002 Parameter ID_WIDTH, default 1: width of t_id.
REQ-003 Parameter DATA_WIDTH, default 64: width of t_data; SHALL be a multiple of 8; STRB_WIDTH = DATA_WIDTH/8.
REQ-004 Parameter DEST_WIDTH, default 1: width of t_dest.
REQ-005 Parameter USER_WIDTH, default 1: width of t_user.
REQ-006 Parameter PACKET_MODE, default 0: 0 selects cut-through; 1 selects store-and-forward.
REQ-007 Port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Ports s_t_valid (in, 1), s_t_ready (out, 1), s_t_id (in, ID_WIDTH), s_t_dest (in, DEST_WIDTH), s_t_data (in, DATA_WIDTH), s_t_strb (in, STRB_WIDTH), s_t_keep (in, STRB_WIDTH), s_t_last (in, 1), s_t_user (in, USER_WIDTH): input stream.
REQ-010 Ports m_t_valid (out, 1), m_t_ready (in, 1), m_t_id, m_t_dest, m_t_data, m_t_strb, m_t_keep, m_t_last, m_t_user (out, widths as REQ-009): output stream.
REQ-011 Port level, output, $clog2(DEPTH)+1 bits: beats currently held in storage, committed and uncommitted.
REQ-012 Port drop, output, 1 bit: one-cycle pulse when a packet is discarded.

Function
REQ-013 A beat SHALL transfer on either port only in a cycle where valid and ready are both high; all seven sideband fields travel with the beat unchanged.
REQ-014 Beat order SHALL be preserved; no beat is duplicated.
REQ-015 s_t_ready SHALL be a register output and SHALL depend on no input in the same cycle.
REQ-016 s_t_ready SHALL be low when level == DEPTH; a read in the same cycle SHALL NOT enable a write in that cycle.
REQ-017 m_t_valid, once high, SHALL stay high with stable payload until accepted.
REQ-018 Cut-through (PACKET_MODE=0): a beat accepted at cycle N SHALL be presentable on m_t_valid no later than cycle N+1 when storage is otherwise empty.
REQ-019 Store-and-forward (PACKET_MODE=1): beats SHALL be written at a write pointer but made readable only via a commit pointer.
REQ-020 Commit pointer SHALL advance to the write pointer in the cycle after the beat with s_t_last=1 is accepted; m_t_valid SHALL be asserted no earlier than cycle N+1 after that last beat's cycle N.
REQ-021 Write-side FSM (PACKET_MODE=1) states: ACCEPT (writing) and DISCARD (consuming an oversize packet).
REQ-022 ACCEPT->DISCARD when uncommitted beats == DEPTH and a non-last beat is offered: write pointer SHALL roll back to commit pointer, drop SHALL pulse next cycle, and s_t_ready SHALL be high in DISCARD.
REQ-023 DISCARD SHALL accept and discard beats; DISCARD->ACCEPT after the beat with s_t_last=1 is accepted.
REQ-024 An oversize beat offered with s_t_last=1 while uncommitted == DEPTH SHALL be accepted, discarded and pulse drop, remaining in ACCEPT.
REQ-025 Level SHALL equal write pointer minus read pointer, using pointers one bit wider than $clog2(DEPTH) with wrap-around modulo 2*DEPTH.
REQ-026 level SHALL update in the cycle after a transfer; simultaneous read and write SHALL leave level unchanged.
REQ-027 With PACKET_MODE=0 the FSM, commit pointer and drop SHALL be inert (drop held 0).

Reset
REQ-028 While rst is high: s_t_ready=0, m_t_valid=0, level=0, drop=0, FSM=ACCEPT, all pointers 0.
REQ-029 The first cycle after rst deasserts, s_t_ready SHALL be 1.
REQ-030 Reset mid-packet SHALL discard all stored and partial beats; no beat accepted before reset SHALL appear afterward.
REQ-031 Output payload fields while m_t_valid=0 are don't-care.

Verification
REQ-032 PACKET_MODE=0, DEPTH=4: write 0x11,0x22,0x33,0x44 with m_t_ready=0 -> level=4, s_t_ready=0; then m_t_ready=1 -> 0x11..0x44 out in order, level returns to 0.
REQ-033 PACKET_MODE=1, DEPTH=8: 3-beat packet, last at cycle N -> m_t_valid stays 0 through N, high at N+1, three beats out with m_t_last only on third.
REQ-034 PACKET_MODE=1, DEPTH=4: 6-beat packet -> drop pulses once, no beat output, level=0 after last beat; next 2-beat packet passes intact.
REQ-035 PACKET_MODE=0: random valid/ready, 1000 beats random sideband -> scoreboard exact match, level never > DEPTH.
REQ-036 PACKET_MODE=1: rst pulsed after 2 beats of 4-beat packet -> m_t_valid=0, level=0; subsequent packet alone is output.
